// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand skew feeder.
package systolic_pkg;

  typedef enum logic [1:0] {FS_IDLE, FS_LOAD, FS_FEED} feeder_state_t;

  function automatic int feed_len(input int lanes, input int depth);
    return depth + lanes - 1;
  endfunction

endpackage

// File: rtl/skew_lane_shifter.sv
// One array-edge lane: holds a captured operand word and emits element[t-OFFSET]
// while t sits inside this lane's diagonal window.
module skew_lane_shifter
  import systolic_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8,
  parameter int OFFSET = 0,
  parameter int T_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DEPTH*DATA_W-1:0] word,
  input  logic                    emit,
  input  logic                    clear,
  input  logic [T_W-1:0]          t,
  output logic [DATA_W-1:0]       data,
  output logic                    valid
);

  logic [DEPTH*DATA_W-1:0] held;
  logic [DATA_W-1:0]       elem;
  logic                    in_win;

  // Unrolled match keeps every select constant-indexed.
  always_comb begin
    elem   = '0;
    in_win = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(t) == OFFSET + k) begin
        elem   = held[k*DATA_W +: DATA_W];
        in_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held  <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) held <= word;
      if (clear) begin
        data  <= '0;
        valid <= 1'b0;
      end else if (emit) begin
        data  <= elem;
        valid <= in_win;
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand staging buffer feeding the systolic array edge with a diagonal skew.
// Optional freeze input enabled by defining SKEW_FEEDER_STALL_EN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:LANES-1]        load_lane,
  input  logic [DEPTH*DATA_W-1:0] load_data,
  input  logic                    feed_start,
  output logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    load_err
`ifdef SKEW_FEEDER_STALL_EN
  ,
  input  logic                    stall
`endif
);

  localparam int             FEED_LEN = feed_len(LANES, DEPTH);
  localparam int             T_W      = $clog2(FEED_LEN + 1);
  localparam logic [T_W-1:0] T_LAST   = T_W'(FEED_LEN - 1);

  feeder_state_t    state;
  logic [LANES-1:0] ld, mask, mask_nxt, cap;
  logic [T_W-1:0]   t;
  logic             drain, hold, emit, clear;

`ifdef SKEW_FEEDER_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    ld = '0;
    for (int i = 0; i < LANES; i++) ld[i] = load_lane[i];
  end

  assign mask_nxt = mask | ld;
  assign cap      = (state != FS_FEED) ? ld : '0;
  // drain marks that the last step is already on the outputs; the next advance retires it.
  assign emit     = (state == FS_FEED) && !hold && !drain;
  assign clear    = (state == FS_FEED) && !hold && drain;
  assign busy     = ((state == FS_LOAD) && (|mask)) || (state == FS_FEED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FS_IDLE;
      mask     <= '0;
      t        <= '0;
      drain    <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FS_IDLE: begin
          if (|ld) begin
            mask  <= ld;
            state <= FS_LOAD;
          end
        end
        FS_LOAD: begin
          mask <= mask_nxt;
          if (feed_start && (&mask_nxt)) begin
            state <= FS_FEED;
            t     <= '0;
            drain <= 1'b0;
          end
        end
        FS_FEED: begin
          if (|ld) load_err <= 1'b1;
          if (!hold) begin
            if (drain) begin
              state <= FS_IDLE;
              done  <= 1'b1;
              mask  <= '0;
              drain <= 1'b0;
            end else if (t == T_LAST) begin
              drain <= 1'b1;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skew_lane_shifter #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .OFFSET(i),
      .T_W   (T_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (cap[i]),
      .word (load_data),
      .emit (emit),
      .clear(clear),
      .t    (t),
      .data (lane_data[i*DATA_W +: DATA_W]),
      .valid(lane_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: directed cases plus randomized load/feed traffic.
module tb_systolic_skew_feeder;

  localparam int LANES  = 2;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 8;
  localparam int FL     = DEPTH + LANES - 1;
  localparam int WW     = DEPTH * DATA_W;
`ifdef SKEW_FEEDER_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [0:LANES-1]        load_lane;
  logic [WW-1:0]           load_data;
  logic                    feed_start;
  logic                    stall;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES-1:0]        lane_valid;
  logic                    busy, done, load_err;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_lane (load_lane),
    .load_data (load_data),
    .feed_start(feed_start),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .busy      (busy),
    .done      (done),
    .load_err  (load_err)
`ifdef SKEW_FEEDER_STALL_EN
    ,
    .stall     (stall)
`endif
  );

  typedef struct packed {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        valid;
    logic                    done;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WW-1:0] words[LANES];
  logic [LANES-1:0] mdl_mask;
  logic          mdl_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Diagonal rule: lane i shows element t-i while 0 <= t-i < DEPTH.
  function automatic exp_t step_out(input int t);
    exp_t e;
    logic [DATA_W-1:0] el;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      if (t >= i && t < i + DEPTH) begin
        el = DATA_W'(words[i] >> ((t - i) * DATA_W));
        e.valid[i] = 1'b1;
        e.data = e.data | ((LANES*DATA_W)'(el) << (i * DATA_W));
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && (|lane_valid || done)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got valid=%b done=%b data=%h, expected no output",
                 lane_valid, done, lane_data);
      end else begin
        mon_e = sb.pop_front();
        chk("lane_data", 64'(lane_data), 64'(mon_e.data));
        chk("lane_valid", 64'(lane_valid), 64'(mon_e.valid));
        chk("done", 64'(done), 64'(mon_e.done));
      end
    end
  end

  task automatic set_ld(input logic [LANES-1:0] bits);
    for (int i = 0; i < LANES; i++) load_lane[i] = bits[i];
  endtask

  task automatic do_load(input logic [LANES-1:0] bits, input logic [WW-1:0] w);
    set_ld(bits);
    load_data = w;
    for (int i = 0; i < LANES; i++) if (bits[i]) words[i] = w;
    mdl_mask = mdl_mask | bits;
    @(negedge clk);
    set_ld('0);
  endtask

  task automatic pulse_feed_only();
    feed_start = 1'b1;
    @(negedge clk);
    feed_start = 1'b0;
  endtask

  // Issue feed_start (optionally with a concurrent completing load), queue the
  // expected stream, then run it out. Stall holds step st_at for st_n extra cycles.
  task automatic do_feed(input logic [LANES-1:0] cl_bits, input logic [WW-1:0] cl_word,
                         input int st_at, input int st_n, input int ld_at);
    exp_t d;
    feed_start = 1'b1;
    set_ld(cl_bits);
    load_data = cl_word;
    for (int i = 0; i < LANES; i++) if (cl_bits[i]) words[i] = cl_word;
    mdl_mask = mdl_mask | cl_bits;
    for (int t = 0; t < FL; t++) begin
      sb.push_back(step_out(t));
      if (t == st_at) for (int r = 0; r < st_n; r++) sb.push_back(step_out(t));
    end
    d = '0;
    d.done = 1'b1;
    sb.push_back(d);
    @(negedge clk);
    feed_start = 1'b0;
    for (int k = 1; k <= FL + st_n + 2; k++) begin
      stall = (st_n > 0) && (k >= st_at + 2) && (k < st_at + 2 + st_n);
      if (k == ld_at) begin
        set_ld(LANES'($urandom_range(1, (1 << LANES) - 1)));
        load_data = WW'($urandom);
        mdl_err = 1'b1;
      end else begin
        set_ld('0);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    set_ld('0);
    mdl_mask = '0;
    #1;
    chk("stream_complete", 64'(sb.size()), 64'd0);
    chk("busy_after_feed", 64'(busy), 64'd0);
    chk("load_err", 64'(load_err), 64'(mdl_err));
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_data"}, 64'(lane_data), 64'd0);
    chk({name, "_valid"}, 64'(lane_valid), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_err"}, 64'(load_err), 64'd0);
  endtask

  initial begin
    logic [LANES-1:0] r, cl;
    int st_at, st_n, ld_at;
    reset = 1'b1;
    set_ld('0);
    load_data = '0;
    feed_start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < LANES; i++) words[i] = '0;
    mdl_mask = '0;
    mdl_err = 1'b0;

    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // feed_start in IDLE does nothing
    pulse_feed_only();
    #1 chk("idle_feed_busy", 64'(busy), 64'd0);

    // Basic load and skewed feed
    do_load(2'b01, 16'h0201);
    #1 chk("load_busy", 64'(busy), 64'd1);
    do_load(2'b10, 16'h0403);
    do_feed('0, '0, -1, 0, 0);

    // Premature feed_start is ignored until the mask completes
    do_load(2'b01, 16'h1211);
    pulse_feed_only();
    repeat (3) @(negedge clk);
    #1 chk("partial_busy", 64'(busy), 64'd1);
    do_load(2'b10, 16'h1413);
    do_feed('0, '0, -1, 0, 0);

    // Reload before feed overwrites lane0
    do_load(2'b01, 16'h0201);
    do_load(2'b10, 16'h0403);
    do_load(2'b01, 16'h0605);
    do_feed('0, '0, -1, 0, 0);

    // Load during feed cycle 1 flags an error; stream untouched; sticky past done
    do_load(2'b11, 16'h2221);
    do_feed('0, '0, -1, 0, 2);
    @(negedge clk);
    #1 chk("err_sticky", 64'(load_err), 64'd1);

    // Reset mid-feed aborts with no done
    do_load(2'b01, 16'h3231);
    do_load(2'b10, 16'h3433);
    feed_start = 1'b1;
    sb.push_back(step_out(0));
    @(negedge clk);
    feed_start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("abort");
    sb.delete();
    mdl_mask = '0;
    mdl_err = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);

    if (HAS_STALL) begin
      do_load(2'b01, 16'h4241);
      do_load(2'b10, 16'h4443);
      do_feed('0, '0, 1, 2, 0);
    end

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      cl = '0;
      for (int g = 0; g < 20; g++) begin
        r = LANES'($urandom_range(1, (1 << LANES) - 1));
        if (mdl_mask != '0 && (mdl_mask | r) == '1 && $urandom_range(0, 1) == 1) begin
          cl = r;
          break;
        end
        do_load(r, WW'($urandom));
        if (mdl_mask == '1) break;
        if ($urandom_range(0, 3) == 0) pulse_feed_only();
      end
      if ((mdl_mask | cl) != '1) do_load('1, WW'($urandom));
      st_at = -1;
      st_n = 0;
      if (HAS_STALL && $urandom_range(0, 1) == 1) begin
        st_at = $urandom_range(0, FL - 1);
        st_n = $urandom_range(1, 3);
      end
      ld_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL + 1 + st_n) : 0;
      do_feed(cl, WW'($urandom), st_at, st_n, ld_at);
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        mdl_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
